// File: rtl/board_ctrl.sv
// board_ctrl: board-level housekeeping block.
//   - clock-enable divider (clk_en once every CLKDIV clk cycles)
//   - per-channel button synchroniser, debouncer and press/release pulses
//   - power-on reset sequencer driving sys_reset (RESET -> HOLD -> RUN)
// Optional feature macro: BOARD_CTRL_BTNRST_EN
//   When defined, button channel 0 acts as a board reset button: pressing it
//   in RUN returns the sequencer to HOLD, and the hold count is frozen at 0
//   while it stays pressed.
// Pulse semantics: btn_press[i] / btn_release[i] are single-cycle strobes
//   with no back-pressure; they are high in exactly the first cycle that
//   btn_level[i] shows its new value, and both are never high together.
module board_ctrl #(
  parameter int CLKDIV   = 6,
  parameter int NBTN     = 2,
  parameter int DEBOUNCE = 4,
  parameter int RSTHOLD  = 8
) (
  input  logic            clk,
  input  logic            power_on_reset_n,
  input  logic [NBTN-1:0] btn_raw,
  output logic            clk_en,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic            sys_reset
);

  localparam int DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HOLD_W = (RSTHOLD > 1) ? $clog2(RSTHOLD) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKDIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RSTHOLD - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_next;
  logic [NBTN-1:0]   sync1;
  logic [NBTN-1:0]   sync2;
  logic [DB_W-1:0]   stab_cnt [NBTN];
  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              btn_hold;

  // Divider next value; wraps after CLKDIV-1 (stays 0 when CLKDIV is 1).
  always_comb begin
    div_next = div_cnt + 1'b1;
    if (div_cnt == DIV_LAST) begin
      div_next = '0;
    end
  end

  // Divider counter and registered tick: clk_en is high while div_cnt sits at CLKDIV-1.
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      div_cnt <= '0;
      clk_en  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      clk_en  <= (div_next == DIV_LAST);
    end
  end

  // Two-flop synchroniser; inversion makes 1 mean pressed from here on.
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~btn_raw;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce on clk_en ticks; edge pulses are set on the toggle itself.
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NBTN; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      if (clk_en) begin
        for (int i = 0; i < NBTN; i++) begin
          if (sync2[i] == btn_level[i]) begin
            stab_cnt[i] <= '0;
          end else if (stab_cnt[i] == DB_LAST) begin
            btn_level[i]   <= ~btn_level[i];
            btn_press[i]   <= ~btn_level[i];
            btn_release[i] <= btn_level[i];
            stab_cnt[i]    <= '0;
          end else begin
            stab_cnt[i] <= stab_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef BOARD_CTRL_BTNRST_EN
  assign btn_hold = btn_level[0];
`else
  assign btn_hold = 1'b0;
`endif

  // Reset sequencer next-state and hold-count logic.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      ST_RESET: begin
        state_next = ST_HOLD;
        hold_next  = '0;
      end
      ST_HOLD: begin
        if (btn_hold) begin
          hold_next = '0;
        end else if (clk_en) begin
          if (hold_cnt == HOLD_LAST) begin
            state_next = ST_RUN;
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (btn_hold) begin
          state_next = ST_HOLD;
          hold_next  = '0;
        end
      end
      default: begin
        state_next = ST_RESET;
        hold_next  = '0;
      end
    endcase
  end

  // Sequencer state, hold counter and registered sys_reset (derived from next state).
  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      state     <= ST_RESET;
      hold_cnt  <= '0;
      sys_reset <= 1'b1;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      sys_reset <= (state_next != ST_RUN);
    end
  end

endmodule
